// File: rtl/core_seq_pkg.sv
// core_seq_pkg
// Shared types and constants for the multi-cycle RV32 sequencer.
//   seq_state_t     : sequencer phase encoding
//   EBREAK_DEFAULT  : instruction word that halts the sequencer
//   TIMEOUT_DEFAULT : default cycle budget for a fetch or data-memory phase
//   is_wait_state   : phases in which the watchdog counts
//   is_clear_state  : phases that precede FETCH/MEM, where the watchdog is zeroed
package core_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        IWAIT,
        EXEC,
        MEM,
        DWAIT,
        WB,
        HALT,
        ERR
    } seq_state_t;

    localparam logic [31:0] EBREAK_DEFAULT  = 32'h0010_0073;
    localparam int          TIMEOUT_DEFAULT = 255;

    // Phases that wait on an external memory handshake.
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == FETCH) || (s == IWAIT) || (s == MEM) || (s == DWAIT);
    endfunction

    // Every path into FETCH or MEM passes through one of these phases, so
    // zeroing the watchdog here means each memory phase starts from zero.
    function automatic logic is_clear_state(input seq_state_t s);
        return (s == IDLE) || (s == EXEC) || (s == WB);
    endfunction

endpackage

// File: rtl/core_seq_if.sv
// core_seq_if
// Bundles the sequencer's memory handshakes, decoder hints and control strobes.
//   imem_*      : instruction fetch request/response
//   instr       : latched instruction handed to decoder/datapath
//   is_mem, is_store, reg_write : decoder hints for the current instruction
//   dmem_*      : data-memory request/response
//   pc_wen, rf_wen : one-cycle write strobes
//   halted, err, retired : status
// Modports: master = sequencer side, slave = memories/decoder/datapath side.
interface core_seq_if #(
    parameter int CNT_W = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rsp_data;
    logic [31:0]      instr;
    logic             is_mem;
    logic             is_store;
    logic             reg_write;
    logic             dmem_req_valid;
    logic             dmem_req_we;
    logic             dmem_req_ready;
    logic             dmem_rsp_valid;
    logic             pc_wen;
    logic             rf_wen;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr,
        input  is_mem,
        input  is_store,
        input  reg_write,
        output dmem_req_valid,
        output dmem_req_we,
        input  dmem_req_ready,
        input  dmem_rsp_valid,
        output pc_wen,
        output rf_wen,
        output halted,
        output err,
        output retired
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr,
        output is_mem,
        output is_store,
        output reg_write,
        input  dmem_req_valid,
        input  dmem_req_we,
        output dmem_req_ready,
        output dmem_rsp_valid,
        input  pc_wen,
        input  rf_wen,
        input  halted,
        input  err,
        input  retired
    );

endinterface

// File: rtl/core_seq_wdog_cnt.sv
// wdog_cnt
// Watchdog shared by the fetch and data-memory phases.
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the count
//   enable   : a waiting phase is active this cycle
//   expire   : this is the TIMEOUT-th waiting cycle since the last clear
module wdog_cnt
    import core_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // count holds the number of waiting cycles already completed, so the
    // cycle in which it equals TIMEOUT-1 is the TIMEOUT-th one.
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Saturating count; the owner leaves the waiting phase when expire fires,
    // so holding at LIMIT only matters if a handshake wins on that cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/core_seq.sv
// core_seq
// Multi-cycle sequencer for the RV32 core: fetches one instruction at a time,
// holds it for the decoder, optionally runs one data-memory transaction, and
// issues exactly one PC/register-file write per instruction.
//   clk  : core clock
//   rst  : synchronous active-high reset
//   bus  : core_seq_if.master (memory handshakes, decoder hints, strobes, status)
// Parameters: TIMEOUT (cycles per memory phase), CNT_W (retired counter
// width), EBREAK (halting instruction word).
module core_seq
    import core_seq_pkg::*;
#(
    parameter int          TIMEOUT = TIMEOUT_DEFAULT,
    parameter int          CNT_W   = 32,
    parameter logic [31:0] EBREAK  = EBREAK_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    core_seq_if.master    bus
);

    seq_state_t       state;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] retired_q;
    logic             imem_req_valid_q;
    logic             dmem_req_valid_q;
    logic             pc_wen_q;
    logic             halted_q;
    logic             err_q;
    logic             wd_expire;

    wdog_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (is_clear_state(state)),
        .enable (is_wait_state(state)),
        .expire (wd_expire)
    );

    // Sequencer FSM. Every output except rf_wen/dmem_req_we is a register set
    // on the transition into the state that owns it, so each strobe is high
    // for exactly the cycles the FSM sits in that state. Response valids are
    // only looked at in IWAIT/DWAIT, which is what makes stray or late
    // responses harmless. A handshake is tested before expiry so that a
    // transfer completing on the last allowed cycle is not reported as error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            instr_q          <= '0;
            retired_q        <= '0;
            imem_req_valid_q <= 1'b0;
            dmem_req_valid_q <= 1'b0;
            pc_wen_q         <= 1'b0;
            halted_q         <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            pc_wen_q <= 1'b0;
            case (state)
                IDLE: begin
                    state            <= FETCH;
                    imem_req_valid_q <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_req_ready) begin
                        state            <= IWAIT;
                        imem_req_valid_q <= 1'b0;
                    end else if (wd_expire) begin
                        state            <= ERR;
                        imem_req_valid_q <= 1'b0;
                        err_q            <= 1'b1;
                    end
                end
                IWAIT: begin
                    if (bus.imem_rsp_valid) begin
                        state   <= EXEC;
                        instr_q <= bus.imem_rsp_data;
                    end else if (wd_expire) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (instr_q == EBREAK) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (bus.is_mem) begin
                        state            <= MEM;
                        dmem_req_valid_q <= 1'b1;
                    end else begin
                        state    <= WB;
                        pc_wen_q <= 1'b1;
                    end
                end
                MEM: begin
                    if (bus.dmem_req_ready) begin
                        state            <= DWAIT;
                        dmem_req_valid_q <= 1'b0;
                    end else if (wd_expire) begin
                        state            <= ERR;
                        dmem_req_valid_q <= 1'b0;
                        err_q            <= 1'b1;
                    end
                end
                DWAIT: begin
                    if (bus.dmem_rsp_valid) begin
                        state    <= WB;
                        pc_wen_q <= 1'b1;
                    end else if (wd_expire) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end
                end
                WB: begin
                    state            <= FETCH;
                    imem_req_valid_q <= 1'b1;
                    retired_q        <= retired_q + 1'b1;
                end
                HALT: begin
                    state <= HALT;
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state            <= IDLE;
                    imem_req_valid_q <= 1'b0;
                    dmem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = imem_req_valid_q;
    assign bus.instr          = instr_q;
    assign bus.dmem_req_valid = dmem_req_valid_q;
    // The write flag simply mirrors the decoder; it is only meaningful while
    // dmem_req_valid is high, and instr (hence is_store) is stable then.
    assign bus.dmem_req_we    = bus.is_store;
    assign bus.pc_wen         = pc_wen_q;
    assign bus.rf_wen         = (state == WB) && bus.reg_write;
    assign bus.halted         = halted_q;
    assign bus.err            = err_q;
    assign bus.retired        = retired_q;

endmodule
